// File: rtl/matrix_addr_gen.sv
`default_nettype none
// ============================================================================
// Module   : matrix_addr_gen
// Purpose  : Walks a 2^R x 2^C tile from a base address in row- or column-major
//            order, emitting {a,row,col} as a valid/ready stream.
// Revision : 1.0 - initial release
// ============================================================================
module matrix_addr_gen #(
  parameter int MSB              = 11,
  parameter int MAT_IDX_SIZE_MSB = 3
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [MAT_IDX_SIZE_MSB:0] row_idx_size,
  input  logic [MAT_IDX_SIZE_MSB:0] col_idx_size,
  input  logic [MSB:0]              base,
  input  logic                      col_major,
  input  logic                      start,
  output logic                      busy,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [MSB:0]              a,
  output logic [MSB:0]              row,
  output logic [MSB:0]              col,
  output logic                      last_inner,
  output logic                      last,
  output logic                      done
);

  localparam int            SW     = MAT_IDX_SIZE_MSB + 1;
  localparam int            W      = MSB + 1;
  localparam logic [MSB:0]  c_ALL1 = '1;
  localparam logic [MSB:0]  c_ONE  = {{MSB{1'b0}}, 1'b1};

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [SW-1:0]   rsz_q, rsz_d, csz_q, csz_d;
  logic [MSB:0]    base_q, base_d;
  logic            cm_q, cm_d;
  logic            busy_q, busy_d, valid_q, valid_d;
  logic [MSB:0]    row_q, row_d, col_q, col_d, a_q, a_d;
  logic            li_q, li_d, last_q, last_d, done_q, done_d;

  logic [MSB:0]    w_rmask, w_cmask, w_nrow, w_ncol;

  // Sizes wider than the bus cannot address more distinct indices.
  function automatic logic [SW-1:0] clamp_sz(input logic [SW-1:0] s);
    if (int'(s) > W) return SW'(W);
    else             return s;
  endfunction

  // Shifting past the bus width yields 0, so the mask saturates to all ones.
  assign w_rmask = ~(c_ALL1 << rsz_q);
  assign w_cmask = ~(c_ALL1 << csz_q);

  always_comb begin
    state_d = state_q;
    rsz_d   = rsz_q;
    csz_d   = csz_q;
    base_d  = base_q;
    cm_d    = cm_q;
    busy_d  = busy_q;
    valid_d = valid_q;
    row_d   = row_q;
    col_d   = col_q;
    a_d     = a_q;
    li_d    = li_q;
    last_d  = last_q;
    done_d  = 1'b0;
    w_nrow  = row_q;
    w_ncol  = col_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          rsz_d   = clamp_sz(row_idx_size);
          csz_d   = clamp_sz(col_idx_size);
          base_d  = base;
          cm_d    = col_major;
          state_d = S_RUN;
          busy_d  = 1'b1;
          valid_d = 1'b1;
          row_d   = '0;
          col_d   = '0;
          a_d     = base;
          li_d    = col_major ? (rsz_d == '0) : (csz_d == '0);
          last_d  = (rsz_d == '0) && (csz_d == '0);
        end
      end
      S_RUN: begin
        if (out_ready) begin
          if (last_q) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            valid_d = 1'b0;
            done_d  = 1'b1;
            li_d    = 1'b0;
            last_d  = 1'b0;
          end else begin
            if (!cm_q) begin
              if (col_q == w_cmask) begin
                w_ncol = '0;
                w_nrow = row_q + c_ONE;
              end else begin
                w_ncol = col_q + c_ONE;
              end
            end else begin
              if (row_q == w_rmask) begin
                w_nrow = '0;
                w_ncol = col_q + c_ONE;
              end else begin
                w_nrow = row_q + c_ONE;
              end
            end
            row_d  = w_nrow;
            col_d  = w_ncol;
            a_d    = base_q + (w_nrow << csz_q) + w_ncol;
            li_d   = cm_q ? (w_nrow == w_rmask) : (w_ncol == w_cmask);
            last_d = (w_nrow == w_rmask) && (w_ncol == w_cmask);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      rsz_q   <= '0;
      csz_q   <= '0;
      base_q  <= '0;
      cm_q    <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      row_q   <= '0;
      col_q   <= '0;
      a_q     <= '0;
      li_q    <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rsz_q   <= rsz_d;
      csz_q   <= csz_d;
      base_q  <= base_d;
      cm_q    <= cm_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      row_q   <= row_d;
      col_q   <= col_d;
      a_q     <= a_d;
      li_q    <= li_d;
      last_q  <= last_d;
      done_q  <= done_d;
    end
  end

  assign busy       = busy_q;
  assign out_valid  = valid_q;
  assign a          = a_q;
  assign row        = row_q;
  assign col        = col_q;
  assign last_inner = li_q;
  assign last       = last_q;
  assign done       = done_q;

endmodule
`default_nettype wire

// File: tb/tb_matrix_addr_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_matrix_addr_gen
// Purpose  : Directed vector table plus multi-cycle sequences for matrix_addr_gen.
// Revision : 1.0 - initial release
// ============================================================================
module tb_matrix_addr_gen;

  logic        CLK = 1'b0;
  logic        RST;
  logic [3:0]  row_idx_size, col_idx_size;
  logic [11:0] base;
  logic        col_major, start, out_ready;
  logic        busy, out_valid, last_inner, last, done;
  logic [11:0] a, row, col;

  matrix_addr_gen #(.MSB(11), .MAT_IDX_SIZE_MSB(3)) dut (
    .CLK(CLK), .RST(RST), .row_idx_size(row_idx_size), .col_idx_size(col_idx_size),
    .base(base), .col_major(col_major), .start(start), .busy(busy),
    .out_valid(out_valid), .out_ready(out_ready), .a(a), .row(row), .col(col),
    .last_inner(last_inner), .last(last), .done(done)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        first;
    logic [3:0]  r, c;
    logic [11:0] bs;
    logic        cm;
    logic [11:0] er, ec, ea;
    logic        eli, elast;
  } vec_t;

  vec_t vt[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic add(input logic f, input logic [3:0] r, input logic [3:0] c,
                     input logic [11:0] bs, input logic cm, input logic [11:0] er,
                     input logic [11:0] ec, input logic [11:0] ea, input logic eli,
                     input logic elast);
    vec_t v;
    v.first = f; v.r = r; v.c = c; v.bs = bs; v.cm = cm;
    v.er = er; v.ec = ec; v.ea = ea; v.eli = eli; v.elast = elast;
    vt.push_back(v);
  endtask

  task automatic issue(input logic [3:0] r, input logic [3:0] c, input logic [11:0] bs,
                       input logic cm);
    @(negedge CLK);
    row_idx_size = r; col_idx_size = c; base = bs; col_major = cm;
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_valid"}, out_valid, 0);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_done"}, done, 0);
    chk({nm, "_a"}, a, 0);
    chk({nm, "_rc"}, {row, col}, 0);
    chk({nm, "_flags"}, {last_inner, last}, 0);
  endtask

  initial begin
    logic       seen;
    int         k, acc;
    logic [7:0] pat;

    RST = 1'b1; start = 1'b0; out_ready = 1'b1;
    row_idx_size = '0; col_idx_size = '0; base = '0; col_major = 1'b0;

    // row-major R=1 C=2
    add(1, 1, 2, 12'h100, 0, 0, 0, 12'h100, 0, 0);
    add(0, 1, 2, 12'h100, 0, 0, 1, 12'h101, 0, 0);
    add(0, 1, 2, 12'h100, 0, 0, 2, 12'h102, 0, 0);
    add(0, 1, 2, 12'h100, 0, 0, 3, 12'h103, 1, 0);
    add(0, 1, 2, 12'h100, 0, 1, 0, 12'h104, 0, 0);
    add(0, 1, 2, 12'h100, 0, 1, 1, 12'h105, 0, 0);
    add(0, 1, 2, 12'h100, 0, 1, 2, 12'h106, 0, 0);
    add(0, 1, 2, 12'h100, 0, 1, 3, 12'h107, 1, 1);
    // column-major R=2 C=1
    add(1, 2, 1, 12'h000, 1, 0, 0, 12'h000, 0, 0);
    add(0, 2, 1, 12'h000, 1, 1, 0, 12'h002, 0, 0);
    add(0, 2, 1, 12'h000, 1, 2, 0, 12'h004, 0, 0);
    add(0, 2, 1, 12'h000, 1, 3, 0, 12'h006, 1, 0);
    add(0, 2, 1, 12'h000, 1, 0, 1, 12'h001, 0, 0);
    add(0, 2, 1, 12'h000, 1, 1, 1, 12'h003, 0, 0);
    add(0, 2, 1, 12'h000, 1, 2, 1, 12'h005, 0, 0);
    add(0, 2, 1, 12'h000, 1, 3, 1, 12'h007, 1, 1);
    // degenerate and wrap
    add(1, 0, 0, 12'hFFF, 0, 0, 0, 12'hFFF, 1, 1);
    add(1, 0, 1, 12'hFFF, 0, 0, 0, 12'hFFF, 0, 0);
    add(0, 0, 1, 12'hFFF, 0, 0, 1, 12'h000, 1, 1);
    // single column row-major, single row column-major
    add(1, 1, 0, 12'h005, 0, 0, 0, 12'h005, 1, 0);
    add(0, 1, 0, 12'h005, 0, 1, 0, 12'h006, 1, 1);
    add(1, 0, 1, 12'h010, 1, 0, 0, 12'h010, 1, 0);
    add(0, 0, 1, 12'h010, 1, 0, 1, 12'h011, 1, 1);

    repeat (3) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    chk_zero("reset");

    for (int i = 0; i < vt.size(); i++) begin
      if (vt[i].first) issue(vt[i].r, vt[i].c, vt[i].bs, vt[i].cm);
      else @(negedge CLK);
      chk($sformatf("v%0d_valid", i), out_valid, 1);
      chk($sformatf("v%0d_busy", i), busy, 1);
      chk($sformatf("v%0d_row", i), row, vt[i].er);
      chk($sformatf("v%0d_col", i), col, vt[i].ec);
      chk($sformatf("v%0d_a", i), a, vt[i].ea);
      chk($sformatf("v%0d_li", i), last_inner, vt[i].eli);
      chk($sformatf("v%0d_last", i), last, vt[i].elast);
      if (vt[i].elast) begin
        @(negedge CLK);
        chk($sformatf("v%0d_done", i), done, 1);
        chk($sformatf("v%0d_idle_valid", i), out_valid, 0);
        chk($sformatf("v%0d_idle_busy", i), busy, 0);
        chk($sformatf("v%0d_hold_a", i), a, vt[i].ea);
        @(negedge CLK);
        chk($sformatf("v%0d_done_pulse", i), done, 0);
      end
    end

    // oversize column size clamps to the bus width: 4096 elements, a wraps
    issue(4'd0, 4'd15, 12'h800, 1'b0);
    seen = 1'b0;
    for (k = 0; k < 4200; k++) begin
      if (k < 4096) begin
        chk("clamp_a", a, (32'h800 + k) & 32'hFFF);
        chk("clamp_col", col, k);
      end
      if (last) begin
        chk("clamp_count", k, 4095);
        seen = 1'b1;
        break;
      end
      @(negedge CLK);
    end
    chk("clamp_last_seen", seen, 1);
    @(negedge CLK);
    chk("clamp_done", done, 1);

    // backpressure: ready pattern 1,0,0,1 then high
    pat = 8'b1111_1001;
    issue(4'd1, 4'd1, 12'h040, 1'b0);
    k = 0; acc = 0; seen = 1'b0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      out_ready = (cyc < 8) ? pat[cyc] : 1'b1;
      if (out_valid) begin
        chk("bp_row", row, k >> 1);
        chk("bp_col", col, k & 1);
        chk("bp_a", a, 32'h40 + k);
        if (out_ready) begin
          acc++;
          k++;
        end
      end
      @(negedge CLK);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    chk("bp_done_seen", seen, 1);
    chk("bp_accepts", acc, 4);
    out_ready = 1'b1;

    // reset on the third element of an 8-element walk
    issue(4'd1, 4'd2, 12'h100, 1'b0);
    @(negedge CLK);
    @(negedge CLK);
    chk("rst_pre_a", a, 12'h102);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    chk_zero("rst_mid");
    @(negedge CLK);
    chk("rst_no_done", done, 0);
    chk("rst_idle", out_valid, 0);
    issue(4'd1, 4'd2, 12'h100, 1'b0);
    chk("rst_restart_rc", {row, col}, 0);
    chk("rst_restart_a", a, 12'h100);
    seen = 1'b0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge CLK);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    chk("rst_restart_done", seen, 1);

    // start held high: ignored in RUN, accepted in done cycle, loses to reset
    @(negedge CLK);
    row_idx_size = 4'd0; col_idx_size = 4'd1; base = 12'h020; col_major = 1'b0;
    start = 1'b1;
    @(negedge CLK);
    chk("b2b_e0_a", a, 12'h020);
    @(negedge CLK);
    chk("b2b_e1_a", a, 12'h021);
    chk("b2b_e1_last", last, 1);
    @(negedge CLK);
    chk("b2b_done", done, 1);
    chk("b2b_done_valid", out_valid, 0);
    @(negedge CLK);
    chk("b2b_next_valid", out_valid, 1);
    chk("b2b_next_a", a, 12'h020);
    chk("b2b_next_rc", {row, col}, 0);
    RST = 1'b1;
    @(negedge CLK);
    chk("rst_start_valid", out_valid, 0);
    @(negedge CLK);
    chk("rst_start_hold_valid", out_valid, 0);
    chk("rst_start_busy", busy, 0);
    RST = 1'b0;
    start = 1'b0;
    @(negedge CLK);
    chk("rst_start_idle", out_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
